// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Purpose  : Program counter and fetch sequencer feeding JC_block; handles
//            redirects, hazard stalls and the post-redirect flush window.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC    = 16'h0000,
    parameter int                FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] jmp_loc,
    input  logic              pc_mux_sel,
    input  logic              stall,
    output logic [ADDR_W-1:0] pm_addr,
    output logic [ADDR_W-1:0] current_address,
    output logic              pc_valid,
    output logic              flush,
    output logic              stalled
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [2:0]        c_flush_load = 3'(FLUSH_CYCLES);
    localparam logic [ADDR_W-1:0] c_pc_step    = ADDR_W'(1);

    state_t            r_state;
    state_t            w_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] w_cur;
    logic [2:0]        r_flush_cnt;
    logic [2:0]        w_flush_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_VEC;
            r_cur       <= RESET_VEC;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state;
            r_pc        <= w_pc;
            r_cur       <= w_cur;
            r_flush_cnt <= w_flush_cnt;
        end
    end

    // Redirect has priority over stall in both RUN and STALL.
    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_cur       = r_cur;
        w_flush_cnt = r_flush_cnt;
        case (r_state)
            ST_BOOT: begin
                w_state = ST_RUN;
            end
            ST_RUN, ST_STALL: begin
                if (pc_mux_sel) begin
                    w_pc        = jmp_loc;
                    w_cur       = r_pc;
                    w_flush_cnt = c_flush_load;
                    w_state     = ST_RUN;
                end else if (stall) begin
                    w_state = ST_STALL;
                end else begin
                    w_pc    = r_pc + c_pc_step;
                    w_cur   = r_pc;
                    w_state = ST_RUN;
                    if (r_flush_cnt != 3'd0) begin
                        w_flush_cnt = r_flush_cnt - 3'd1;
                    end
                end
            end
            default: begin
                w_state = ST_BOOT;
            end
        endcase
    end

    // All outputs decode registers only; nothing passes straight from inputs.
    assign pm_addr         = r_pc;
    assign current_address = r_cur;
    assign pc_valid        = (r_state != ST_BOOT);
    assign flush           = (r_flush_cnt != 3'd0);
    assign stalled         = (r_state == ST_STALL);

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Purpose  : Directed and random checks of pc_fetch_unit against a
//            behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam int          ADDR_W       = 16;
    localparam logic [15:0] RESET_VEC    = 16'h0000;
    localparam int          FLUSH_CYCLES = 2;

    logic        clk;
    logic        reset;
    logic [15:0] jmp_loc;
    logic        pc_mux_sel;
    logic        stall;
    logic [15:0] pm_addr;
    logic [15:0] current_address;
    logic        pc_valid;
    logic        flush;
    logic        stalled;

    pc_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .RESET_VEC   (RESET_VEC),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .jmp_loc        (jmp_loc),
        .pc_mux_sel     (pc_mux_sel),
        .stall          (stall),
        .pm_addr        (pm_addr),
        .current_address(current_address),
        .pc_valid       (pc_valid),
        .flush          (flush),
        .stalled        (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: plain variables describing what the pipeline should show.
    bit          m_booted;
    bit          m_stalled;
    logic [15:0] m_pc;
    logic [15:0] m_cur;
    int          m_flush_left;

    task automatic model_reset();
        m_booted     = 1'b0;
        m_stalled    = 1'b0;
        m_pc         = RESET_VEC;
        m_cur        = RESET_VEC;
        m_flush_left = 0;
    endtask

    task automatic model_edge(input logic [15:0] j, input logic sel, input logic stl);
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (sel) begin
            m_cur        = m_pc;
            m_pc         = j;
            m_flush_left = FLUSH_CYCLES;
            m_stalled    = 1'b0;
        end else if (stl) begin
            m_stalled = 1'b1;
        end else begin
            m_cur     = m_pc;
            m_pc      = 16'((int'(m_pc) + 1) % 65536);
            m_stalled = 1'b0;
            if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
        end
    endtask

    task automatic check_one(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all(input string tag);
        check_one({tag, ".pm_addr"}, pm_addr, m_pc);
        check_one({tag, ".current_address"}, current_address, m_cur);
        check_one({tag, ".pc_valid"}, {15'd0, pc_valid}, {15'd0, m_booted});
        check_one({tag, ".flush"}, {15'd0, flush}, {15'd0, (m_flush_left != 0)});
        check_one({tag, ".stalled"}, {15'd0, stalled}, {15'd0, m_stalled});
    endtask

    // Apply inputs, take one rising edge, then compare 1 ns later.
    task automatic step(input string tag, input logic [15:0] j, input logic sel, input logic stl);
        jmp_loc    = j;
        pc_mux_sel = sel;
        stall      = stl;
        @(posedge clk);
        model_edge(j, sel, stl);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] rj;
        logic        rs;
        logic        rt;

        reset      = 1'b0;
        jmp_loc    = 16'h0000;
        pc_mux_sel = 1'b0;
        stall      = 1'b0;
        model_reset();
        #4;
        check_all("in_reset");
        #5;
        reset = 1'b1;

        // BOOT ignores both redirect and stall.
        step("boot", 16'h1234, 1'b1, 1'b1);
        check_one("boot_pm_addr_zero", pm_addr, 16'h0000);
        step("run1", 16'h0, 1'b0, 1'b0);
        check_one("run1_pm", pm_addr, 16'h0001);
        step("run2", 16'h0, 1'b0, 1'b0);
        step("run3", 16'h0, 1'b0, 1'b0);
        check_one("run3_cur", current_address, 16'h0002);
        step("run4", 16'h0, 1'b0, 1'b0);
        step("run5", 16'h0, 1'b0, 1'b0);

        step("redir8", 16'h0008, 1'b1, 1'b0);
        check_one("redir8_pm", pm_addr, 16'h0008);
        check_one("redir8_cur", current_address, 16'h0005);
        step("post8a", 16'h0, 1'b0, 1'b0);
        check_one("post8a_flush", {15'd0, flush}, 16'h0001);
        step("post8b", 16'h0, 1'b0, 1'b0);
        check_one("post8b_flush", {15'd0, flush}, 16'h0000);
        check_one("post8b_pm", pm_addr, 16'h000A);

        step("redir10", 16'h0010, 1'b1, 1'b0);
        step("fl10a", 16'h0, 1'b0, 1'b1);
        step("stall2", 16'h0, 1'b0, 1'b1);
        step("stall3", 16'h0, 1'b0, 1'b1);
        check_one("stall3_pm", pm_addr, 16'h0010);
        check_one("stall3_st", {15'd0, stalled}, 16'h0001);
        step("unstall", 16'h0, 1'b0, 1'b0);
        check_one("unstall_pm", pm_addr, 16'h0011);
        step("stall_again", 16'h0, 1'b0, 1'b1);
        step("redir_in_stall", 16'h0020, 1'b1, 1'b1);
        check_one("ris_pm", pm_addr, 16'h0020);

        step("idle_a", 16'h0, 1'b0, 1'b0);
        step("idle_b", 16'h0, 1'b0, 1'b0);
        step("b2b_30", 16'h0030, 1'b1, 1'b0);
        step("b2b_40", 16'h0040, 1'b1, 1'b0);
        check_one("b2b_pm", pm_addr, 16'h0040);
        step("b2b_f1", 16'h0, 1'b0, 1'b0);
        step("b2b_f2", 16'h0, 1'b0, 1'b0);

        step("wrap_redir", 16'hFFFF, 1'b1, 1'b0);
        step("wrap0", 16'h0, 1'b0, 1'b0);
        check_one("wrap0_pm", pm_addr, 16'h0000);
        step("wrap1", 16'h0, 1'b0, 1'b0);

        step("pre_rst_redir", 16'h0100, 1'b1, 1'b0);
        step("pre_rst_stall", 16'h0, 1'b0, 1'b1);
        async_reset_pulse("async_rst");
        step("reboot", 16'h0, 1'b0, 1'b0);
        step("rerun1", 16'h0, 1'b0, 1'b0);
        check_one("rerun1_pm", pm_addr, 16'h0001);

        for (int i = 0; i < 300; i++) begin
            rj = 16'($urandom);
            rs = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 3) == 0);
            step("rand", rj, rs, rt);
            if (i == 150) async_reset_pulse("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
